reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- General-purpose register file for the 16-bit CPU datapath: 16 registers of 16 bits each.
- Two asynchronous (combinational) read ports feed the ALU operands A and B.
- One synchronous write port takes the ALU/writeback result.
- Every register, including r0, is an ordinary writable register; none is hardwired to zero.

Parameters:
- WIDTH, 16, data width of each register and of the wd/rd1/rd2 ports.
- NREGS, 16, number of registers.
- AW, 4, address width; NREGS must equal 2**AW.

Ports:
- clk  input  1  system clock (50 MHz); all writes happen on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- regwrite  input  1  write enable, sampled on the rising clk edge.
- wa  input  AW  write address.
- wd  input  WIDTH  write data.
- ra1  input  AW  read address, port 1.
- ra2  input  AW  read address, port 2.
- rd1  output  WIDTH  read data, port 1.
- rd2  output  WIDTH  read data, port 2.

Behaviour:
- Storage: array of NREGS x WIDTH flip-flops. The block uses no memory macro, so async reset is possible.
- Reset:
  - rst_n low immediately clears all registers to 16'h0000, independent of clk.
  - While rst_n is low, rd1 and rd2 therefore read 0 and writes are ignored.
  - Release is synchronous in effect: the first write can take effect on the first rising edge with rst_n high.
- Write:
  - On rising clk with rst_n high and regwrite=1, mem[wa] <= wd.
  - With regwrite=0, no register changes.
  - Exactly one register is written per cycle.
- Read:
  - rd1 = mem[ra1] and rd2 = mem[ra2], purely combinational with zero cycle latency.
  - Outputs change whenever the address or the addressed register changes.
- Read-during-write (same address): no bypass.
  - Before the edge, rd shows the old value.
  - After the edge, it shows wd within the same delta/propagation.
  - Verification must sample reads after the write edge.
- Same address on both ports: ra1==ra2 is legal, and both outputs show the same value.
- Back-to-back writes to the same address: the last write wins.
- Writes to different addresses in consecutive cycles: all are retained.
- r0 is fully writable and readable.
- Unknown or undriven inputs: if regwrite is X, the implementation need not define behaviour. Verification drives all inputs to known values after reset.
- Addresses are always in range (AW bits cover all NREGS), so no out-of-range handling is needed.

Decomposition:
- Shared CPU package holds:
  - DATA_W = 16
  - REG_AW = 4
  - NUM_REGS = 16
  - typedef word_t (logic [15:0])
  - typedef regaddr_t (logic [3:0])
- reg_file uses these types for its ports and parameter defaults.
- No sub-module: a single always_ff block for writes/reset, plus two continuous-assign read muxes.

Test Plan:
- Reset: assert rst_n=0 mid-run after writing r5=16'h1234 -> all rd1/rd2 reads for addresses 0..15 return 16'h0000 immediately, without waiting for a clk edge.
- Basic write/read:
  - Stimulus: regwrite=1, wa=3, wd=16'h000A, one edge; then wa=2, wd=16'h000A, one edge; then regwrite=0, ra1=3, ra2=2.
  - Response: rd1=10, rd2=10.
- Dual read including r0:
  - Stimulus: write r0=16'hFFFF and r1=16'hFFFF; set ra1=0, ra2=1.
  - Response: rd1=rd2=65535.
  - Then write r0=16'hA5A5 and r1=16'h5FBD -> rd1=16'hA5A5, rd2=16'h5FBD.
- Write disable:
  - Stimulus: regwrite=0, wa=1, wd=16'h0001 across several edges.
  - Response: r1 keeps 16'h5FBD.
- Read-during-write timing:
  - Stimulus: ra1=4 while writing r4=16'h0001 over r4=16'hFFFF.
  - Response: rd1=16'hFFFF before the edge and 16'h0001 after it.
  - Also: ra1=ra2=4 -> both outputs equal.
- Overwrite and full sweep:
  - Stimulus: write r[i]=i*16'h1111 for i=0..15 (wrapping mod 2^16); then overwrite r7=16'h0000.
  - Response: every register reads back its own value, r7=0, and no other register is disturbed.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared CPU datapath package: register-file geometry and the word/address
// types used by the datapath blocks.
package reg_file_pkg;

   localparam int DATA_W   = 16;
   localparam int REG_AW   = 4;
   localparam int NUM_REGS = 16;

   typedef logic [DATA_W-1:0] word_t;
   typedef logic [REG_AW-1:0] regaddr_t;

endpackage : reg_file_pkg

// File: rtl/reg_file.sv
// General-purpose register file: NREGS x WIDTH flip-flops, two combinational
// read ports (ALU operands A and B), one synchronous write port.
// Every register, r0 included, is ordinary storage; nothing is hardwired.
// There is no write-to-read bypass: a read of the register being written
// shows the old value until the clock edge, then the new one.
module reg_file
   import reg_file_pkg::*;
#(
   parameter int WIDTH = DATA_W,
   parameter int NREGS = NUM_REGS,
   parameter int AW    = REG_AW
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             regwrite,
   input  logic [AW-1:0]    wa,
   input  logic [WIDTH-1:0] wd,
   input  logic [AW-1:0]    ra1,
   input  logic [AW-1:0]    ra2,
   output logic [WIDTH-1:0] rd1,
   output logic [WIDTH-1:0] rd2
);

   // The address must cover every register exactly, so no range check is
   // needed on any port.
   if (NREGS != (2 ** AW)) begin : g_bad_geometry
      $error("reg_file: NREGS must equal 2**AW");
   end

   logic [WIDTH-1:0] mem_q [NREGS];
   logic [WIDTH-1:0] mem_d [NREGS];

   // Next-state: hold every register, then replace the one addressed by wa
   // when the write is enabled (exactly one register per cycle).
   always_comb begin
      mem_d = mem_q;
      if (regwrite) begin
         mem_d[wa] = wd;
      end
   end

   // Storage: asynchronous clear of the whole array, otherwise load next-state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= '{default: '0};
      end else begin
         mem_q <= mem_d;
      end
   end

   // Read ports are plain muxes on the register outputs: zero cycle latency.
   assign rd1 = mem_q[ra1];
   assign rd2 = mem_q[ra2];

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: table-driven vectors, hand-written
// multi-cycle sequences and a scoreboard queue of expected read data.
`timescale 1ns/1ps
module tb_reg_file;
   import reg_file_pkg::*;

   // ---------------- clock / reset ----------------
   logic     clk = 1'b0;
   logic     rst_n;
   logic     regwrite;
   regaddr_t wa, ra1, ra2;
   word_t    wd, rd1, rd2;

   always #10 clk = ~clk;

   reg_file dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .regwrite (regwrite),
      .wa       (wa),
      .wd       (wd),
      .ra1      (ra1),
      .ra2      (ra2),
      .rd1      (rd1),
      .rd2      (rd2)
   );

   // ---------------- scoreboard ----------------
   word_t       model_mem [NUM_REGS];
   logic [15:0] exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic check_next(input string name, input word_t actual);
      word_t exp_v;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL %s: got %h, no expected value queued", name, actual);
      end else begin
         exp_v = exp_q.pop_front();
         if (actual !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, actual, exp_v);
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   // Drive one write cycle (called 1ns after a rising edge), return 1ns after
   // the next rising edge with regwrite released.
   task automatic drive_write(input logic we, input regaddr_t a, input word_t d);
      regwrite = we;
      wa       = a;
      wd       = d;
      @(posedge clk);
      #1;
      regwrite = 1'b0;
      if (we && rst_n) model_mem[a] = d;
   endtask

   // Set read addresses, queue the expected data, sample 2ns later.
   task automatic expect_read(input string name, input regaddr_t a1, input regaddr_t a2,
                              input word_t e1, input word_t e2);
      ra1 = a1;
      ra2 = a2;
      exp_q.push_back(e1);
      exp_q.push_back(e2);
      #2;
      check_next({name, ".rd1"}, rd1);
      check_next({name, ".rd2"}, rd2);
   endtask

   task automatic expect_model(input string name, input regaddr_t a1, input regaddr_t a2);
      expect_read(name, a1, a2, model_mem[a1], model_mem[a2]);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic     we;
      regaddr_t wa;
      word_t    wd;
      regaddr_t ra1;
      regaddr_t ra2;
      word_t    exp1;
      word_t    exp2;
   } vec_t;

   localparam int NVEC = 11;
   vec_t vecs [NVEC];

   // ---------------- watchdog ----------------
   initial begin
      #200us;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   // ---------------- main test ----------------
   initial begin
      //            we    wa     wd        ra1    ra2    exp1      exp2
      vecs[0]  = '{1'b1, 4'd3, 16'h000A, 4'd3,  4'd3,  16'h000A, 16'h000A};
      vecs[1]  = '{1'b1, 4'd2, 16'h000A, 4'd3,  4'd2,  16'h000A, 16'h000A};
      vecs[2]  = '{1'b0, 4'd3, 16'h0000, 4'd3,  4'd2,  16'h000A, 16'h000A};
      vecs[3]  = '{1'b1, 4'd0, 16'hFFFF, 4'd0,  4'd3,  16'hFFFF, 16'h000A};
      vecs[4]  = '{1'b1, 4'd1, 16'hFFFF, 4'd0,  4'd1,  16'hFFFF, 16'hFFFF};
      vecs[5]  = '{1'b1, 4'd0, 16'hA5A5, 4'd0,  4'd1,  16'hA5A5, 16'hFFFF};
      vecs[6]  = '{1'b1, 4'd1, 16'h5FBD, 4'd0,  4'd1,  16'hA5A5, 16'h5FBD};
      vecs[7]  = '{1'b0, 4'd1, 16'h0001, 4'd1,  4'd0,  16'h5FBD, 16'hA5A5};
      vecs[8]  = '{1'b0, 4'd1, 16'h0001, 4'd1,  4'd1,  16'h5FBD, 16'h5FBD};
      vecs[9]  = '{1'b0, 4'd1, 16'h0001, 4'd1,  4'd2,  16'h5FBD, 16'h000A};
      vecs[10] = '{1'b1, 4'd4, 16'hFFFF, 4'd4,  4'd4,  16'hFFFF, 16'hFFFF};

      for (int i = 0; i < NUM_REGS; i++) model_mem[i] = '0;
      rst_n    = 1'b0;
      regwrite = 1'b0;
      wa       = '0;
      wd       = '0;
      ra1      = '0;
      ra2      = '0;

      // Reset state: everything reads zero, an enabled write is ignored.
      regwrite = 1'b1;
      wa       = 4'd6;
      wd       = 16'hDEAD;
      @(posedge clk);
      #1;
      regwrite = 1'b0;
      expect_read("reset_r0_r6", 4'd0, 4'd6, 16'h0000, 16'h0000);
      expect_read("reset_r15_r8", 4'd15, 4'd8, 16'h0000, 16'h0000);
      #5;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Table: write/read, dual read with r0, write disable.
      for (int i = 0; i < NVEC; i++) begin
         drive_write(vecs[i].we, vecs[i].wa, vecs[i].wd);
         expect_read($sformatf("vec%0d", i), vecs[i].ra1, vecs[i].ra2,
                     vecs[i].exp1, vecs[i].exp2);
      end

      // Read-during-write on r4 (holds FFFF): old value before the edge,
      // new value after it, both ports on the same address.
      ra1      = 4'd4;
      ra2      = 4'd4;
      regwrite = 1'b1;
      wa       = 4'd4;
      wd       = 16'h0001;
      exp_q.push_back(16'hFFFF);
      exp_q.push_back(16'hFFFF);
      #1;
      check_next("rdw_before.rd1", rd1);
      check_next("rdw_before.rd2", rd2);
      @(posedge clk);
      #1;
      regwrite = 1'b0;
      model_mem[4] = 16'h0001;
      expect_read("rdw_after", 4'd4, 4'd4, 16'h0001, 16'h0001);

      // Back-to-back writes to one address: last write wins.
      drive_write(1'b1, 4'd6, 16'h1111);
      drive_write(1'b1, 4'd6, 16'h2222);
      expect_read("b2b_r6", 4'd6, 4'd0, 16'h2222, 16'hA5A5);

      // Full sweep r[i] = i*0x1111, then overwrite r7 with zero.
      for (int i = 0; i < NUM_REGS; i++) drive_write(1'b1, 4'(i), 16'(i * 16'h1111));
      drive_write(1'b1, 4'd7, 16'h0000);
      for (int i = 0; i < NUM_REGS; i++) begin
         expect_read($sformatf("sweep%0d", i), 4'(i), 4'(15 - i),
                     (i == 7) ? 16'h0000 : 16'(i * 16'h1111),
                     (i == 8) ? 16'h0000 : 16'((15 - i) * 16'h1111));
      end

      // Mid-run reset: write r5, then pull rst_n low between edges and read
      // every address before any clock edge can occur.
      drive_write(1'b1, 4'd5, 16'h1234);
      expect_read("pre_reset_r5", 4'd5, 4'd5, 16'h1234, 16'h1234);
      @(posedge clk);
      #1;
      rst_n    = 1'b0;
      regwrite = 1'b1;
      wa       = 4'd5;
      wd       = 16'hBEEF;
      for (int i = 0; i < NUM_REGS; i++) begin
         ra1 = 4'(i);
         ra2 = 4'(15 - i);
         exp_q.push_back(16'h0000);
         exp_q.push_back(16'h0000);
         #1;
         check_next($sformatf("async_rst%0d.rd1", i), rd1);
         check_next($sformatf("async_rst%0d.rd2", i), rd2);
      end
      for (int i = 0; i < NUM_REGS; i++) model_mem[i] = '0;
      // Writes held high across edges while in reset are ignored.
      repeat (2) @(posedge clk);
      #1;
      expect_read("rst_hold_r5", 4'd5, 4'd0, 16'h0000, 16'h0000);

      // Release between edges with a write pending: it lands on the first edge.
      wa = 4'd9;
      wd = 16'h0909;
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      regwrite = 1'b0;
      model_mem[9] = 16'h0909;
      expect_read("post_release_r9", 4'd9, 4'd5, 16'h0909, 16'h0000);

      // Random writes and reads checked against the model.
      for (int i = 0; i < 40; i++) begin
         drive_write(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                     16'($urandom_range(0, 65535)));
         expect_model($sformatf("rand%0d", i), 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)));
      end

      // ---------------- final report ----------------
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_reg_file
